// File: rtl/harmonic_accum.sv
// Harmonic mixer: sums sine(h) * mult(h) over a harmonic series, then scales and saturates
// the sum into one output sample. Sequences an external multiplier stage and sine source.
module harmonic_accum #(
    parameter int DIV_BIT    = 11,
    parameter int SAMPLE_BIT = 16,
    parameter int ACC_BIT    = 36,
    parameter int OUT_SHIFT  = 11
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset_n,
    input  logic                  i_Sample_Start,
    input  logic [6:0]            i_Harmonic_Count,
    output logic                  o_Restart,
    output logic                  o_Scale_Start,
    input  logic [DIV_BIT-1:0]    i_Mult,
    input  logic                  i_Mult_Ready,
    output logic                  o_Sine_Req,
    output logic [6:0]            o_Harmonic,
    input  logic [SAMPLE_BIT-1:0] i_Sine,
    input  logic                  i_Sine_Valid,
    output logic [SAMPLE_BIT-1:0] o_Sample,
    output logic                  o_Sample_Valid,
    output logic                  o_Busy,
    output logic                  o_Overrun
);

    localparam int PROD_W = SAMPLE_BIT + DIV_BIT + 1;

    typedef enum logic [2:0] {
        StIdle,
        StRestart,
        StWaitMult,
        StWaitSine,
        StAdvance,
        StOutput
    } state_t;

    state_t                      state_q, state_d;
    logic [6:0]                  count_q, count_d;
    logic [6:0]                  harmonic_q, harmonic_d;
    logic [DIV_BIT-1:0]          mult_q, mult_d;
    logic signed [ACC_BIT-1:0]   acc_q, acc_d;
    logic [SAMPLE_BIT-1:0]       sample_q, sample_d;
    logic                        sample_valid_q, sample_valid_d;
    logic                        sine_req_q, sine_req_d;
    logic                        overrun_q, overrun_d;
    logic                        guard_q, guard_d;

    logic signed [PROD_W-1:0]    sine_ext, mult_ext, product;
    logic signed [ACC_BIT-1:0]   product_ext, shifted;
    logic [ACC_BIT-SAMPLE_BIT:0] shifted_hi;
    logic [SAMPLE_BIT-1:0]       saturated;

    // Multiplier is unsigned, so it is zero-extended before the signed multiply.
    assign sine_ext    = {{(DIV_BIT + 1){i_Sine[SAMPLE_BIT-1]}}, i_Sine};
    assign mult_ext    = {{(SAMPLE_BIT + 1){1'b0}}, mult_q};
    assign product     = sine_ext * mult_ext;
    assign product_ext = {{(ACC_BIT - PROD_W){product[PROD_W-1]}}, product};

    assign shifted    = acc_q >>> OUT_SHIFT;
    assign shifted_hi = shifted[ACC_BIT-1:SAMPLE_BIT-1];

    always_comb begin
        saturated = shifted[SAMPLE_BIT-1:0];
        if (!((&shifted_hi) || !(|shifted_hi))) begin
            saturated = shifted[ACC_BIT-1] ? {1'b1, {(SAMPLE_BIT - 1){1'b0}}}
                                           : {1'b0, {(SAMPLE_BIT - 1){1'b1}}};
        end
    end

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        harmonic_d     = harmonic_q;
        mult_d         = mult_q;
        acc_d          = acc_q;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        sine_req_d     = 1'b0;
        guard_d        = guard_q;
        overrun_d      = i_Sample_Start && (state_q != StIdle);

        case (state_q)
            StIdle: begin
                if (i_Sample_Start) begin
                    count_d    = i_Harmonic_Count;
                    acc_d      = '0;
                    harmonic_d = '0;
                    state_d    = StRestart;
                end
            end
            StRestart: begin
                guard_d = 1'b1;
                state_d = StWaitMult;
            end
            StWaitMult: begin
                // Ready may still reflect the previous multiplier on the first cycle.
                if (guard_q) begin
                    guard_d = 1'b0;
                end else if (i_Mult_Ready) begin
                    if (i_Mult == '0) begin
                        state_d = StOutput;
                    end else begin
                        sine_req_d = 1'b1;
                        mult_d     = i_Mult;
                        state_d    = StWaitSine;
                    end
                end
            end
            StWaitSine: begin
                if (i_Sine_Valid) begin
                    acc_d   = acc_q + product_ext;
                    state_d = (harmonic_q == count_q) ? StOutput : StAdvance;
                end
            end
            StAdvance: begin
                harmonic_d = harmonic_q + 7'd1;
                guard_d    = 1'b1;
                state_d    = StWaitMult;
            end
            StOutput: begin
                sample_d       = saturated;
                sample_valid_d = 1'b1;
                state_d        = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q        <= StIdle;
            count_q        <= '0;
            harmonic_q     <= '0;
            mult_q         <= '0;
            acc_q          <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            sine_req_q     <= 1'b0;
            overrun_q      <= 1'b0;
            guard_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            harmonic_q     <= harmonic_d;
            mult_q         <= mult_d;
            acc_q          <= acc_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            sine_req_q     <= sine_req_d;
            overrun_q      <= overrun_d;
            guard_q        <= guard_d;
        end
    end

    assign o_Restart      = (state_q == StRestart);
    assign o_Scale_Start  = (state_q == StAdvance);
    assign o_Busy         = (state_q != StIdle);
    assign o_Sine_Req     = sine_req_q;
    assign o_Harmonic     = harmonic_q;
    assign o_Sample       = sample_q;
    assign o_Sample_Valid = sample_valid_q;
    assign o_Overrun      = overrun_q;

endmodule

// File: doc/harmonic_accum.md
HARMONIC_ACCUM -- requirements
Module: harmonic_accum

Interface
REQ-001 SHALL have parameters: DIV_BIT, default 11, multiplier width; SAMPLE_BIT, default 16, sine/output width; ACC_BIT, default 36, accumulator width; OUT_SHIFT, default 11, output right-shift.
REQ-002 SHALL have ports:
- i_Clock  in  1  system clock
- i_Reset_n  in  1  asynchronous, active-low reset
- i_Sample_Start  in  1  pulse: begin one output sample
- i_Harmonic_Count  in  7  harmonics after the fundamental
- o_Restart  out  1  pulse: reload multiplier stage to initial value
- o_Scale_Start  out  1  pulse: advance multiplier stage one harmonic
- i_Mult  in  DIV_BIT  unsigned current multiplier
- i_Mult_Ready  in  1  multiplier valid
- o_Sine_Req  out  1  pulse: request sine for o_Harmonic
- o_Harmonic  out  7  harmonic index (0 = fundamental)
- i_Sine  in  SAMPLE_BIT  signed sine value
- i_Sine_Valid  in  1  pulse: i_Sine valid
- o_Sample  out  SAMPLE_BIT  signed mixed sample
- o_Sample_Valid  out  1  pulse: o_Sample updated
- o_Busy  out  1  sample in progress
- o_Overrun  out  1  pulse: start dropped while busy

Function
REQ-003 SHALL implement states IDLE, RESTART, WAIT_MULT, WAIT_SINE, ADVANCE, OUTPUT.
REQ-004 IDLE: on i_Sample_Start SHALL latch i_Harmonic_Count, clear accumulator, set o_Harmonic=0, go RESTART.
REQ-005 RESTART: SHALL hold o_Restart high exactly one cycle, then go WAIT_MULT.
REQ-006 WAIT_MULT: SHALL ignore i_Mult_Ready on its first cycle (guard); thereafter, when i_Mult_Ready=1, SHALL go OUTPUT if i_Mult==0, else SHALL pulse o_Sine_Req one cycle, latch i_Mult, and go WAIT_SINE.
REQ-007 WAIT_SINE: on i_Sine_Valid SHALL add signed(i_Sine) times unsigned latched multiplier (zero-extended, SAMPLE_BIT+DIV_BIT product) into the ACC_BIT signed accumulator. SHALL go OUTPUT if o_Harmonic equals the latched count, else ADVANCE.
REQ-008 ADVANCE: SHALL pulse o_Scale_Start one cycle, increment o_Harmonic, go WAIT_MULT.
REQ-009 OUTPUT: SHALL set o_Sample = accumulator arithmetic-shifted right by OUT_SHIFT, saturated to signed SAMPLE_BIT range. SHALL pulse o_Sample_Valid one cycle, go IDLE.
REQ-010 SHALL process at most latched count+1 harmonics; count=0 means fundamental only, with no o_Scale_Start.
REQ-011 SHALL terminate early on i_Mult==0 without issuing o_Sine_Req for that harmonic.
REQ-012 o_Busy SHALL be high in every state except IDLE.
REQ-013 i_Sample_Start outside IDLE SHALL be ignored and SHALL pulse o_Overrun one cycle; the in-progress sample SHALL be unaffected.
REQ-014 i_Sine_Valid outside WAIT_SINE and i_Mult_Ready outside WAIT_MULT SHALL be ignored.
REQ-015 o_Sample SHALL hold its value between o_Sample_Valid pulses.
REQ-016 The accumulator SHALL not wrap for 128 full-scale terms (ACC_BIT >= SAMPLE_BIT+DIV_BIT+7).

Reset
REQ-017 i_Reset_n low SHALL immediately force state IDLE, accumulator 0, and all outputs 0 (o_Sample, o_Harmonic, and all pulses/flags), independent of i_Clock.
REQ-018 Reset mid-sample SHALL abandon the sample; no o_Sample_Valid SHALL occur until a new i_Sample_Start after release.

Verification
REQ-019 Count=0, initial mult 2047, sine 16384 -> one o_Sine_Req, zero o_Scale_Start, o_Sample=16376, one valid pulse.
REQ-020 Count=3, initial 2000, scale step 500, sine 1000 each -> mults 2000/1500/1000/500, 4 o_Sine_Req, 3 o_Scale_Start, o_Sample=2441.
REQ-021 Count=10, initial 1000, scale 600, sine 2048 -> mults 1000/400/0, 2 o_Sine_Req, 2 o_Scale_Start, early stop, o_Sample=1400.
REQ-022 Count=15, initial 2047, scale 0, sine 32767 -> o_Sample=32767; sine -32768 -> o_Sample=-32768.
REQ-023 i_Sample_Start pulsed during WAIT_SINE -> o_Overrun pulse, first sample result unchanged, no second o_Restart.
REQ-024 i_Reset_n low during WAIT_SINE -> outputs 0 before next clock edge; after release, no o_Sample_Valid until new start.
